// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon autoplayer: FSM state, 2-bit light code,
// one-hot conversions and default timing/depth constants.
package simon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_PRESS   = 2'd2,
      ST_GAP     = 2'd3
   } state_e;

   typedef logic [1:0] light_code_t;

   localparam int DEF_DEPTH = 64;
   localparam int DEF_HOLD  = 2;
   localparam int DEF_GAP   = 1;

   function automatic logic [3:0] code_to_onehot(input light_code_t code);
      return 4'b0001 << code;
   endfunction

   function automatic light_code_t onehot_to_code(input logic [3:0] lights);
      light_code_t code;
      code = 2'd0;
      case (lights)
         4'b0010: code = 2'd1;
         4'b0100: code = 2'd2;
         4'b1000: code = 2'd3;
         default: code = 2'd0;
      endcase
      return code;
   endfunction

   function automatic logic is_one_hot(input logic [3:0] lights);
      return (lights != 4'h0) && ((lights & (lights - 4'h1)) == 4'h0);
   endfunction

endpackage

// File: rtl/simon_seq_buf.sv
// Captured-sequence storage: DEPTH x 2-bit register array, one write port and
// one asynchronous read port. Contents are deliberately not reset.
module simon_seq_buf
   import simon_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  light_code_t       wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output light_code_t       rdata_o
);

   light_code_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_autoplayer.sv
// Simon autoplayer: records the lights Simon shows, then replays them on the switches.
// Optional SIMON_AUTO_MISTAKE_EN adds miss_en_i/miss_idx_i to deliberately fumble one press.
//
// state    | meaning
// ST_IDLE  | waiting for simons_turn to rise with en set
// ST_CAPTURE | recording one code per 0 -> one-hot light transition
// ST_PRESS | driving one switch for HOLD cycles
// ST_GAP   | all switches off for GAP cycles before the next press or done
module simon_autoplayer
   import simon_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int HOLD  = DEF_HOLD,
   parameter int GAP   = DEF_GAP
)(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        en_i,
   input  logic        simons_turn_i,
   input  logic [3:0]  lights_i,
`ifdef SIMON_AUTO_MISTAKE_EN
   input  logic        miss_en_i,
   input  logic [7:0]  miss_idx_i,
`endif
   output logic [3:0]  sw_out_o,
   output logic        busy_o,
   output logic [7:0]  seq_len_o,
   output logic        overflow_o,
   output logic        done_o
);

   localparam int AW   = $clog2(DEPTH);
   localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   state_e       state_q;
   logic         turn_q, turn_vld_q;
   logic [3:0]   lights_q;
   logic [8:0]   cnt_q, rd_q;
   logic [TW-1:0] timer_q;
   logic [3:0]   sw_out_q;
   logic         busy_q, ovf_q, done_q;

   logic         turn_rise, new_light, we;
   logic [8:0]   rd_nxt;
   logic [AW-1:0] raddr;
   light_code_t  rcode, play_code;

   always_comb begin
      turn_rise = turn_vld_q && !turn_q && simons_turn_i;
      new_light = (lights_q == 4'h0) && is_one_hot(lights_i);
      we        = en_i && (state_q == ST_CAPTURE) && simons_turn_i && new_light &&
                  (cnt_q != 9'(DEPTH));
      rd_nxt    = rd_q + 9'd1;
      // From CAPTURE the first press is entry 0; from GAP it is the next entry.
      raddr     = (state_q == ST_GAP) ? rd_nxt[AW-1:0] : '0;
      play_code = rcode;
`ifdef SIMON_AUTO_MISTAKE_EN
      if (miss_en_i && ({1'b0, miss_idx_i} == ((state_q == ST_GAP) ? rd_nxt : 9'd0)))
         play_code = rcode + 2'd1;
`endif
   end

   simon_seq_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk_i   (clk_i),
      .we_i    (we),
      .waddr_i (cnt_q[AW-1:0]),
      .wdata_i (onehot_to_code(lights_i)),
      .raddr_i (raddr),
      .rdata_o (rcode)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         turn_q     <= 1'b0;
         turn_vld_q <= 1'b0;
         lights_q   <= 4'h0;
         cnt_q      <= '0;
         rd_q       <= '0;
         timer_q    <= '0;
         sw_out_q   <= 4'h0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         turn_q     <= simons_turn_i;
         turn_vld_q <= 1'b1;
         lights_q   <= lights_i;
         done_q     <= 1'b0;
         if (!en_i) begin
            state_q  <= ST_IDLE;
            sw_out_q <= 4'h0;
            busy_q   <= 1'b0;
         end else if (turn_rise) begin
            // A new Simon turn restarts capture from any state, aborting playback.
            state_q  <= ST_CAPTURE;
            busy_q   <= 1'b1;
            sw_out_q <= 4'h0;
            cnt_q    <= '0;
            rd_q     <= '0;
            ovf_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_CAPTURE: begin
                  if (!simons_turn_i) begin
                     if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q  <= ST_PRESS;
                        rd_q     <= '0;
                        sw_out_q <= code_to_onehot(play_code);
                        timer_q  <= TW'(HOLD - 1);
                     end
                  end else if (new_light) begin
                     if (cnt_q == 9'(DEPTH)) ovf_q <= 1'b1;
                     else                    cnt_q <= cnt_q + 9'd1;
                  end
               end
               ST_PRESS: begin
                  if (timer_q == '0) begin
                     state_q  <= ST_GAP;
                     sw_out_q <= 4'h0;
                     timer_q  <= TW'(GAP - 1);
                  end else begin
                     timer_q <= timer_q - TW'(1);
                  end
               end
               ST_GAP: begin
                  if (timer_q == '0) begin
                     if (rd_nxt < cnt_q) begin
                        state_q  <= ST_PRESS;
                        rd_q     <= rd_nxt;
                        sw_out_q <= code_to_onehot(play_code);
                        timer_q  <= TW'(HOLD - 1);
                     end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     timer_q <= timer_q - TW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sw_out_o   = sw_out_q;
   assign busy_o     = busy_q;
   assign seq_len_o  = cnt_q[8] ? 8'hFF : cnt_q[7:0];
   assign overflow_o = ovf_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Scoreboard bench for simon_autoplayer (DEPTH=4, HOLD=2, GAP=1): expected per-cycle
// {busy, done, sw_out} is queued when playback is triggered and compared every cycle.
module tb_simon_autoplayer;
   import simon_pkg::*;

   localparam int HOLD = 2;
   localparam int GAP  = 1;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       en_i = 1'b1;
   logic       simons_turn_i = 1'b0;
   logic [3:0] lights_i = 4'h0;
   logic [3:0] sw_out_o;
   logic       busy_o, overflow_o, done_o;
   logic [7:0] seq_len_o;
`ifdef SIMON_AUTO_MISTAKE_EN
   logic       miss_en_i = 1'b0;
   logic [7:0] miss_idx_i = 8'd0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] press_q[$];
   logic [5:0] sb_q[$];

   always #5 clk_i = ~clk_i;

   simon_autoplayer #(.DEPTH(4), .HOLD(HOLD), .GAP(GAP)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .en_i          (en_i),
      .simons_turn_i (simons_turn_i),
      .lights_i      (lights_i),
`ifdef SIMON_AUTO_MISTAKE_EN
      .miss_en_i     (miss_en_i),
      .miss_idx_i    (miss_idx_i),
`endif
      .sw_out_o      (sw_out_o),
      .busy_o        (busy_o),
      .seq_len_o     (seq_len_o),
      .overflow_o    (overflow_o),
      .done_o        (done_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic begin_capture();
      simons_turn_i = 1'b1;
      tick();
      tick();
   endtask

   task automatic show(input logic [3:0] l);
      lights_i = l;
      tick();
      tick();
      lights_i = 4'h0;
      tick();
   endtask

   // Queue the expected playback for press_q, end Simon's turn, then score every cycle.
   task automatic finish_play(input string tag);
      foreach (press_q[i]) begin
         repeat (HOLD) sb_q.push_back({2'b10, press_q[i]});
         repeat (GAP)  sb_q.push_back(6'b100000);
      end
      sb_q.push_back(6'b010000);
      sb_q.push_back(6'b000000);
      press_q.delete();
      simons_turn_i = 1'b0;
      while (sb_q.size() > 0) begin
         tick();
         chk(tag, {busy_o, done_o, sw_out_o}, sb_q.pop_front());
      end
   endtask

   initial begin
      tick();
      chk("rst_sw", sw_out_o, 4'h0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_len", seq_len_o, 8'd0);
      chk("rst_ovf", overflow_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      rst_n_i = 1'b1;
      tick();
      tick();

      // basic three-press round
      begin_capture();
      chk("cap_busy", busy_o, 1'b1);
      show(4'h1); show(4'h8); show(4'h2);
      chk("len3", seq_len_o, 8'd3);
      press_q = '{4'h1, 4'h8, 4'h2};
      finish_play("play_182");
      chk("len3_after", seq_len_o, 8'd3);
      chk("ovf_none", overflow_o, 1'b0);

      // all-lit flash ignored, non-one-hot ignored
      begin_capture();
      show(4'hF); show(4'h4); show(4'h5);
      chk("len1", seq_len_o, 8'd1);
      press_q = '{4'h4};
      finish_play("play_allF");

      // overflow at DEPTH=4
      begin_capture();
      show(4'h1); show(4'h2); show(4'h4); show(4'h8); show(4'h1); show(4'h2);
      chk("len_sat", seq_len_o, 8'd4);
      chk("ovf_set", overflow_o, 1'b1);
      press_q = '{4'h1, 4'h2, 4'h4, 4'h8};
      finish_play("play_ovf");
      chk("ovf_sticky", overflow_o, 1'b1);

      // abort by new Simon turn during 2nd press
      begin_capture();
      chk("ovf_clear", overflow_o, 1'b0);
      show(4'h1); show(4'h2); show(4'h4);
      simons_turn_i = 1'b0;
      tick(); tick(); tick(); tick();
      chk("abort_pre", sw_out_o, 4'h2);
      simons_turn_i = 1'b1;
      tick();
      chk("abort_sw", sw_out_o, 4'h0);
      chk("abort_busy", busy_o, 1'b1);
      chk("abort_len", seq_len_o, 8'd0);
      chk("abort_done", done_o, 1'b0);
      simons_turn_i = 1'b0;
      tick();
      chk("empty_idle", {busy_o, done_o, sw_out_o}, 6'd0);
      tick();
      chk("empty_nodone", done_o, 1'b0);

      // turn falls together with a new light: light not recorded
      begin_capture();
      show(4'h1);
      lights_i = 4'h2;
      press_q = '{4'h1};
      finish_play("play_fall");
      lights_i = 4'h0;
      chk("fall_len", seq_len_o, 8'd1);
      tick();

      // en low during playback
      begin_capture();
      show(4'h1); show(4'h2);
      simons_turn_i = 1'b0;
      tick();
      chk("en_pre", sw_out_o, 4'h1);
      en_i = 1'b0;
      tick();
      chk("en_sw", {busy_o, sw_out_o}, 5'd0);
      chk("en_len", seq_len_o, 8'd2);
      tick();
      chk("en_nodone", done_o, 1'b0);
      en_i = 1'b1;
      tick();

      // asynchronous reset mid-press
      begin_capture();
      show(4'h8);
      simons_turn_i = 1'b0;
      tick();
      chk("ar_pre", sw_out_o, 4'h8);
      #2 rst_n_i = 1'b0;
      #1;
      chk("ar_sw", sw_out_o, 4'h0);
      chk("ar_busy", busy_o, 1'b0);
      chk("ar_len", seq_len_o, 8'd0);
      simons_turn_i = 1'b1;
      tick();
      rst_n_i = 1'b1;
      tick();
      tick();
      chk("ar_noturn", busy_o, 1'b0);
      simons_turn_i = 1'b0;
      tick();

`ifdef SIMON_AUTO_MISTAKE_EN
      miss_en_i  = 1'b1;
      miss_idx_i = 8'd1;
      begin_capture();
      show(4'h1); show(4'h2); show(4'h4);
      press_q = '{4'h1, 4'h4, 4'h4};
      finish_play("play_miss");
      miss_idx_i = 8'd7;
      begin_capture();
      show(4'h2); show(4'h8);
      press_q = '{4'h2, 4'h8};
      finish_play("play_miss_oob");
      miss_en_i = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
